instr_loader: RTL and testbench
===============================

# instr_loader

Boot-time program loader for the single-cycle core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them into instruction memory through a write port. That write port is the counterpart of the core's read-only fetch port. While loading, the core is held in reset; the loader releases it only after the last word has been written.

## Interface
- ADDR_WIDTH, 10, word-address width of instruction memory; capacity is 2**ADDR_WIDTH words
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  one-cycle instruction-memory write strobe
- mem_addr  output  32  byte address of the write (word index * 4, bits [1:0] = 0)
- mem_wd  output  32  word to write
- core_rst  output  1  active-low reset to the core: 0 = hold, 1 = run
- done  output  1  load finished successfully, level
- error  output  1  load aborted, level

## Operation
- Frame format: 4-byte word count N (little-endian), then N words of 4 bytes each (little-endian, first byte goes to bits [7:0]), then an optional checksum byte (see Configuration).
- A byte transfers on a rising edge where in_valid=1 and in_ready=1. in_data is ignored otherwise.
- States:
  - LEN: collect the 4 count bytes. On the 4th byte:
    - N > 2**ADDR_WIDTH -> ERR.
    - N = 0 -> CSUM if enabled, else RUN.
    - otherwise -> DATA.
  - DATA: collect bytes into a shift register, with a 2-bit byte counter and a word index counter. On every 4th byte, register mem_wd, set mem_addr = index*4 and pulse mem_we, then increment the index. When index reaches N -> CSUM or RUN.
  - CSUM: accept exactly one byte and compare it. Match -> RUN; mismatch -> ERR.
  - RUN: terminal. in_ready=0, done=1, core_rst=1.
  - ERR: terminal. in_ready=0, error=1, core_rst=0. No further writes.
- in_ready=1 in LEN, DATA and CSUM.
- Leaving RUN or ERR requires reset.
- Count arithmetic uses 32 bits. The index counter is ADDR_WIDTH+1 bits wide, so N = 2**ADDR_WIDTH is legal and fills memory exactly.

## Timing
- Reset values (asynchronous, immediate): state=LEN, all counters 0, in_ready=1, mem_we=0, mem_addr=0, mem_wd=0, core_rst=0, done=0, error=0.
- Word write: if the 4th byte of a word is accepted on edge T, then mem_we=1 with the valid mem_addr/mem_wd during the cycle after T. mem_we is low the following cycle unless another word completes.
- Back-to-back bytes (in_valid held high) are accepted every cycle, with no bubbles. Maximum write rate is one word per 4 cycles.
- Release: core_rst and done rise one cycle after the final mem_we pulse, so the core never fetches before the last write has landed. With N=0, core_rst rises on the edge after the last frame byte.
- error rises on the edge that accepts the offending byte (4th count byte, or checksum byte).
- If reset asserts mid-load, the partial word is discarded and already-written words are left in memory. After reset deasserts, loading restarts from LEN.
- in_valid dropping mid-word only stalls the load. There is no timeout.

## Configuration
- LOADER_CHECKSUM_EN defined: a trailing checksum byte is required after the data, including when N=0.
  - The byte must equal the XOR of all data bytes, with the count bytes excluded.
  - Match -> RUN; mismatch -> ERR.
- LOADER_CHECKSUM_EN undefined: there is no CSUM state, and the frame ends after the last data byte.

## Test plan
- Reset then N=1, word 0x00500093 sent as 93 00 50 00 -> exactly one mem_we with mem_addr=0x0 and mem_wd=0x00500093; core_rst=1 and done=1 one cycle later.
- N=3, continuous in_valid -> mem_we at byte-accept cycles 8, 12 and 16 (counted from the first count byte), addresses 0x0, 0x4, 0x8; in_ready=0 after release.
- N=2**ADDR_WIDTH+1 (0x00000401 for default) -> error=1 after the 4th count byte, no mem_we ever, core_rst stays 0.
- Gaps: in_valid toggled randomly during N=2 -> same words and addresses as with a continuous stream; no extra mem_we pulses.
- Reset asserted after 6 data bytes of N=4 -> all outputs return to reset values immediately; a fresh full frame then loads correctly.
- With LOADER_CHECKSUM_EN, N=1, word 0x11223344, checksum 0x44 -> done=1. Same frame with checksum 0x45 -> error=1 and core_rst stays 0; the mem_we pulse for the data word still occurred.

Source files
------------

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - boot loader: byte stream -> little-endian words -> instruction memory, core held in reset until done.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  localparam logic [31:0]         CAPACITY = 32'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] IDX_ONE  = 1;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_RUN,
    S_ERR
  } state_t;

  state_t                state, state_next;
  logic [1:0]            byte_cnt;
  logic [23:0]           shreg;
  logic [ADDR_WIDTH:0]   idx;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   idx_next;
  logic [31:0]           word;
  logic                  accept;
  logic                  last_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  assign word      = {in_data, shreg};
  assign accept    = in_valid && in_ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign idx_next  = idx + IDX_ONE;
  assign core_rst  = done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LEN;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    error      = 1'b0;
    case (state)
      S_LEN: begin
        in_ready = 1'b1;
        if (accept && last_byte) begin
          if (word > CAPACITY) state_next = S_ERR;
`ifdef LOADER_CHECKSUM_EN
          else if (word == 32'd0) state_next = S_CSUM;
`else
          else if (word == 32'd0) state_next = S_RUN;
`endif
          else state_next = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (accept && last_byte && idx_next == count) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = S_CSUM;
`else
          state_next = S_RUN;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        if (accept) state_next = (in_data == csum) ? S_RUN : S_ERR;
      end
`endif
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // done is registered so release trails the final write strobe by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= 2'd0;
      shreg    <= 24'd0;
      idx      <= '0;
      count    <= '0;
      mem_we   <= 1'b0;
      mem_addr <= 32'd0;
      mem_wd   <= 32'd0;
      done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= (state == S_RUN);
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        shreg    <= {in_data, shreg[23:8]};
        if (state == S_LEN && last_byte) count <= word[ADDR_WIDTH:0];
        if (state == S_DATA) begin
`ifdef LOADER_CHECKSUM_EN
          csum <= csum ^ in_data;
`endif
          if (last_byte) begin
            mem_we   <= 1'b1;
            mem_wd   <= word;
            mem_addr <= {{(30-ADDR_WIDTH){1'b0}}, idx[ADDR_WIDTH-1:0], 2'b00};
            idx      <= idx_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized frames for instr_loader checked against a frame-level reference model.
module tb_instr_loader;

  localparam int          AW  = 10;
  localparam logic [31:0] CAP = 32'd1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        core_rst;
  logic        done;
  logic        error;

  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .core_rst(core_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] words[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_cyc[$];
  int          acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wd);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
    chk("rst_mem_addr", mem_addr,          32'd0);
    chk("rst_mem_wd",   mem_wd,            32'd0);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_error",    {31'd0, error},    32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Starts and ends 1ns after a rising edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  g;
    bit  rdy;
    bit  ok;
    g = gaps ? $urandom_range(0, 3) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 8 && !ok; t++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc_cyc.push_back(cyc);
        ok = 1'b1;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic run_frame(input logic [31:0] n, input bit gaps, input bit bad_csum);
    logic [7:0]  bq[$];
    logic [31:0] w;
    logic [7:0]  x;
    int          exp_writes;
    bit          exp_err;
    int          nobs;
    do_reset();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); acc_cyc.delete();
    x = 8'd0;
    for (int i = 0; i < 4; i++) bq.push_back(n[8*i +: 8]);
    if (n > CAP) begin
      exp_err    = 1'b1;
      exp_writes = 0;
    end else begin
      exp_writes = int'(n);
      for (int k = 0; k < exp_writes; k++) begin
        w = words[k];
        for (int b = 0; b < 4; b++) begin
          bq.push_back(w[8*b +: 8]);
          x = x ^ w[8*b +: 8];
        end
      end
`ifdef LOADER_CHECKSUM_EN
      bq.push_back(bad_csum ? (x ^ 8'h01) : x);
      exp_err = bad_csum;
`else
      exp_err = 1'b0;
`endif
    end
    foreach (bq[i]) send_byte(bq[i], gaps);
    in_valid = 1'b0;

    @(negedge clk);
    if (exp_err) begin
      chk("err_error",    {31'd0, error},    32'd1);
      chk("err_core_rst", {31'd0, core_rst}, 32'd0);
      chk("err_done",     {31'd0, done},     32'd0);
      chk("err_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("err_core_rst_hold", {31'd0, core_rst}, 32'd0);
    end else begin
      chk("rel_done_early", {31'd0, done},     32'd0);
      chk("rel_in_ready",   {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk("rel_done",     {31'd0, done},     32'd1);
      chk("rel_core_rst", {31'd0, core_rst}, 32'd1);
      chk("rel_error",    {31'd0, error},    32'd0);
    end

    chk("nwrites", obs_addr.size(), exp_writes);
    for (int k = 0; k < exp_writes && k < obs_addr.size(); k++) begin
      chk("wr_addr", obs_addr[k], 32'(k * 4));
      chk("wr_data", obs_data[k], words[k]);
      chk("wr_cyc",  obs_cyc[k],  acc_cyc[4 + 4*k + 3]);
    end
    if (!exp_err && exp_writes > 0) begin
      // release cycle must follow the final strobe by exactly one cycle
      chk("rel_after_we", cyc, obs_cyc[obs_cyc.size()-1] + 1);
    end

    nobs = obs_addr.size();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      chk("term_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("term_no_writes", obs_addr.size(), nobs);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'd0;

    words.delete();
    words.push_back(32'h0050_0093);
    run_frame(32'd1, 1'b0, 1'b0);

    fill_words(3);
    run_frame(32'd3, 1'b0, 1'b0);

    run_frame(CAP + 32'd1, 1'b0, 1'b0);
    run_frame(32'hFFFF_FFFF, 1'b1, 1'b0);

    fill_words(2);
    run_frame(32'd2, 1'b1, 1'b0);

    run_frame(32'd0, 1'b0, 1'b0);

    // mid-load reset after 6 data bytes of a 4-word frame
    fill_words(4);
    do_reset();
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete(); acc_cyc.delete();
    for (int i = 0; i < 4; i++) send_byte(8'((32'd4 >> (8*i))), 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'(words[i/4] >> (8*(i%4))), 1'b0);
    #2;
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_vals();
    chk("midrst_nwrites", obs_addr.size(), 1);
    if (obs_addr.size() > 0) chk("midrst_wd", obs_data[0], words[0]);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    fill_words(4);
    run_frame(32'd4, 1'b1, 1'b0);

    fill_words(int'(CAP));
    run_frame(CAP, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    words.delete();
    words.push_back(32'h1122_3344);
    run_frame(32'd1, 1'b0, 1'b0);
    run_frame(32'd1, 1'b0, 1'b1);
    run_frame(32'd0, 1'b0, 1'b1);
`endif

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, 8);
      fill_words(n);
      run_frame(32'(n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
